// File: rtl/regdelay_var.sv
// Runtime-programmable, stall-aware delay line for W-bit words with a valid flag.
// Behaves as a D-stage shift register clocked by (clk & step), built on a circular buffer.
module regdelay_var #(
  parameter int W  = 8,
  parameter int N  = 16,
  parameter int DW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          step,
  input  logic          flush,
  input  logic          load,
  input  logic [DW-1:0] dly_in,
  input  logic          in_valid,
  input  logic [W-1:0]  in,
  output logic          out_valid,
  output logic [W-1:0]  out,
  output logic          primed,
  output logic [DW-1:0] dly
);

  localparam int PW = $clog2(N);
  localparam logic [DW-1:0] NMAX = DW'(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  logic [N-1:0]  vld;
  logic [W-1:0]  dat [N];
  logic [PW-1:0] wp;
  logic [DW-1:0] cnt;

  logic [PW-1:0] off;
  logic [PW-1:0] rd_idx;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic [DW-1:0] dly_san;

  // The output register is the D-th stage, so the buffer only holds D-1 words;
  // the oldest of them sits D-1 slots behind the write pointer.
  always_comb begin
    off = PW'(dly - DW'(1));
    if (wp >= off) begin
      rd_idx = wp - off;
    end else begin
      rd_idx = wp + PW'(N) - off;
    end
    if (dly == DW'(1)) begin
      rd_valid = in_valid;
      rd_data  = in;
    end else begin
      rd_valid = vld[rd_idx];
      rd_data  = dat[rd_idx];
    end
  end

  always_comb begin
    if (dly_in == '0) begin
      dly_san = DW'(1);
    end else if (dly_in > NMAX) begin
      dly_san = NMAX;
    end else begin
      dly_san = dly_in;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vld       <= '0;
      wp        <= '0;
      cnt       <= '0;
      dly       <= NMAX;
      out_valid <= 1'b0;
      out       <= '0;
    end else if (load) begin
      vld       <= '0;
      cnt       <= '0;
      dly       <= dly_san;
      out_valid <= 1'b0;
      out       <= '0;
    end else if (flush) begin
      vld       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out       <= '0;
    end else if (step) begin
      vld[wp]   <= in_valid;
      wp        <= (wp == LAST) ? '0 : wp + PW'(1);
      out_valid <= rd_valid;
      out       <= rd_valid ? rd_data : '0;
      if (cnt != NMAX) begin
        cnt <= cnt + DW'(1);
      end
    end
  end

  // Data words need no reset; stale contents are masked by the cleared valid flags.
  always_ff @(posedge clk) begin
    if (step && !load && !flush) begin
      dat[wp] <= in;
    end
  end

  assign primed = (cnt >= dly);

endmodule

// File: tb/tb_regdelay_var.sv
// Directed self-checking bench for regdelay_var with hand-computed expectations.
module tb_regdelay_var;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int DW = $clog2(N + 1);

  logic          clk;
  logic          clr_n;
  logic          step;
  logic          flush;
  logic          load;
  logic [DW-1:0] dly_in;
  logic          in_valid;
  logic [W-1:0]  in;
  logic          out_valid;
  logic [W-1:0]  out;
  logic          primed;
  logic [DW-1:0] dly;

  int checks;
  int passes;

  regdelay_var #(.W(W), .N(N), .DW(DW)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .step     (step),
    .flush    (flush),
    .load     (load),
    .dly_in   (dly_in),
    .in_valid (in_valid),
    .in       (in),
    .out_valid(out_valid),
    .out      (out),
    .primed   (primed),
    .dly      (dly)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      passes++;
    end
  endtask

  // Drive one cycle of inputs and return 1 time unit after the rising edge.
  task automatic applyStimulus(input logic s, input logic f, input logic l,
                               input logic [DW-1:0] d, input logic v, input logic [W-1:0] x);
    step     = s;
    flush    = f;
    load     = l;
    dly_in   = d;
    in_valid = v;
    in       = x;
    @(posedge clk);
    #1;
  endtask

  task automatic checkStream(input string tag, input logic ev, input logic [W-1:0] eo, input logic ep);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    checkOutput({tag, " out"}, 32'(out), 32'(eo));
    checkOutput({tag, " primed"}, 32'(primed), 32'(ep));
  endtask

  initial begin
    logic [W-1:0] words [4];
    logic         ev;
    logic [W-1:0] eo;
    checks   = 0;
    passes   = 0;
    clr_n    = 1'b0;
    step     = 1'b0;
    flush    = 1'b0;
    load     = 1'b0;
    dly_in   = '0;
    in_valid = 1'b0;
    in       = '0;
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    words[3] = 8'h44;

    repeat (2) @(posedge clk);
    #1;
    checkStream("reset", 1'b0, 8'h00, 1'b0);
    checkOutput("reset dly", 32'(dly), 32'(N));
    clr_n = 1'b1;

    // D=3 streaming with trailing bubbles
    applyStimulus(1, 0, 1, 5'd3, 1, 8'h77);
    checkOutput("load3 dly", 32'(dly), 32'd3);
    checkStream("load3", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 0, 5'd3, (i < 4), (i < 4) ? words[i] : 8'hFF);
      ev = (i >= 2) && (i < 6);
      eo = ev ? words[i-2] : 8'h00;
      checkStream($sformatf("d3 edge%0d", i + 1), ev, eo, (i >= 2));
    end

    // D=3 with step toggling; word A1 enters on the first step edge only
    applyStimulus(0, 0, 1, 5'd3, 0, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      if (c % 2 == 1) begin
        applyStimulus(1, 0, 0, 5'd3, (c == 1), (c == 1) ? 8'hA1 : 8'h00);
      end else begin
        applyStimulus(0, 0, 0, 5'd3, 1, 8'hEE);
      end
      checkStream($sformatf("stall clk%0d", c), (c == 5), (c == 5) ? 8'hA1 : 8'h00, (c == 5));
    end
    applyStimulus(0, 0, 0, 5'd3, 1, 8'hEE);
    checkStream("stall hold1", 1'b1, 8'hA1, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 5'd9, 1, 8'hEE);
    checkStream("stall hold2", 1'b1, 8'hA1, 1'b1);
    checkOutput("no load dly", 32'(dly), 32'd3);
    applyStimulus(1, 0, 0, 5'd3, 0, 8'h00);
    checkStream("stall bubble", 1'b0, 8'h00, 1'b1);

    // Load boundaries: 0 -> 1, N+5 -> N
    applyStimulus(1, 0, 1, 5'd0, 1, 8'h66);
    checkOutput("load0 dly", 32'(dly), 32'd1);
    applyStimulus(1, 0, 0, 5'd0, 1, 8'h5A);
    checkStream("d1 word", 1'b1, 8'h5A, 1'b1);
    applyStimulus(1, 0, 0, 5'd0, 0, 8'h00);
    checkStream("d1 bubble", 1'b0, 8'h00, 1'b1);
    applyStimulus(1, 0, 1, 5'(N + 5), 1, 8'h66);
    checkOutput("loadmax dly", 32'(dly), 32'(N));
    for (int j = 0; j < 56; j++) begin
      applyStimulus(1, 0, 0, 5'd0, (j < 40), (j < 40) ? 8'(j) : 8'hFF);
      ev = (j >= N - 1) && (j < N - 1 + 40);
      eo = ev ? 8'(j - (N - 1)) : 8'h00;
      checkOutput($sformatf("wrap v%0d", j), 32'(out_valid), 32'(ev));
      checkOutput($sformatf("wrap d%0d", j), 32'(out), 32'(eo));
    end
    checkOutput("wrap primed", 32'(primed), 32'd1);

    // D=4 streaming with flush on cycle 6
    applyStimulus(1, 0, 1, 5'd4, 1, 8'h66);
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(1, (c == 6), 0, 5'd4, 1, 8'(8'h50 + c));
      ev = (c < 6) ? (c >= 4) : (c >= 10);
      eo = ev ? 8'(8'h50 + c - 3) : 8'h00;
      checkStream($sformatf("flush clk%0d", c), ev, eo, ev);
    end

    // load + flush + step together while data is in flight
    applyStimulus(1, 1, 1, 5'd2, 1, 8'h99);
    checkOutput("ldfl dly", 32'(dly), 32'd2);
    checkStream("ldfl", 1'b0, 8'h00, 1'b0);
    applyStimulus(1, 0, 0, 5'd7, 1, 8'hB1);
    checkStream("ldfl edge1", 1'b0, 8'h00, 1'b0);
    applyStimulus(1, 0, 0, 5'd7, 0, 8'h00);
    checkStream("ldfl edge2", 1'b1, 8'hB1, 1'b1);
    applyStimulus(1, 0, 0, 5'd7, 0, 8'h00);
    checkStream("ldfl edge3", 1'b0, 8'h00, 1'b1);
    checkOutput("ldfl dly hold", 32'(dly), 32'd2);

    // asynchronous reset mid-cycle with data in flight
    applyStimulus(1, 0, 1, 5'd3, 0, 8'h00);
    applyStimulus(1, 0, 0, 5'd3, 1, 8'hC1);
    applyStimulus(1, 0, 0, 5'd3, 1, 8'hC2);
    applyStimulus(1, 0, 0, 5'd3, 1, 8'hC3);
    checkStream("pre reset", 1'b1, 8'hC1, 1'b1);
    #3;
    clr_n = 1'b0;
    #1;
    checkStream("async reset", 1'b0, 8'h00, 1'b0);
    checkOutput("async reset dly", 32'(dly), 32'(N));
    step = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      applyStimulus(1, 0, 0, 5'd3, (j == 0), (j == 0) ? 8'hD1 : 8'h00);
      ev = (j == N - 1);
      checkStream($sformatf("post reset %0d", j), ev, ev ? 8'hD1 : 8'h00, (j >= N - 1));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
